// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr
//   Switch allocator plus crossbar for a NoC router. Every output arbitrates
//   among the inputs that request it. The arbitration is round-robin, and
//   wormhole locking keeps a packet's flits together at an output. The
//   winning flit is written into a registered output stage that honours
//   downstream backpressure.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active high
//   in_req     one-hot output request per input, slice [i*NPORTS +: NPORTS]
//   in_data    flit per input, slice [i*DATASIZE +: DATASIZE]; [1:0] = type
//   in_ready   input i consumed this cycle (or it had no request)
//   out_full   downstream of output o cannot accept
//   out_valid  output register o holds a valid flit
//   out_data   output register contents, slice [o*DATASIZE +: DATASIZE]
//   grant      combinational grant, slice [o*NPORTS +: NPORTS] one-hot over inputs
module switch_alloc_rr #(
  parameter int NPORTS   = 5,
  parameter int DATASIZE = 40,
  parameter int PTRW     = $clog2(NPORTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS*NPORTS-1:0]     in_req,
  input  logic [NPORTS*DATASIZE-1:0]   in_data,
  output logic [NPORTS-1:0]            in_ready,
  input  logic [NPORTS-1:0]            out_full,
  output logic [NPORTS-1:0]            out_valid,
  output logic [NPORTS*DATASIZE-1:0]   out_data,
  output logic [NPORTS*NPORTS-1:0]     grant
);

  localparam logic [PTRW:0] NPORTS_W  = (PTRW+1)'(NPORTS);
  localparam logic [1:0]    FT_SINGLE = 2'b00;
  localparam logic [1:0]    FT_HEAD   = 2'b01;
  localparam logic [1:0]    FT_TAIL   = 2'b11;

  logic [PTRW-1:0]     ptr      [NPORTS];
  logic [NPORTS-1:0]   lock_v;
  logic [PTRW-1:0]     lock_own [NPORTS];

  logic [NPORTS-1:0]   elig     [NPORTS];   // elig[o][i]
  logic [NPORTS-1:0]   gnt_v;
  logic [PTRW-1:0]     gnt_idx  [NPORTS];
  logic [PTRW-1:0]     ptr_nxt  [NPORTS];
  logic [DATASIZE-1:0] win_flit [NPORTS];
  logic [NPORTS-1:0]   xfer;
  logic [PTRW:0]       cand;
  logic [PTRW:0]       inc;

  // Per-output arbitration. The candidate index is ptr+k, and it wraps
  // once past NPORTS, so the search is a rotation that starts at ptr.
  always_comb begin
    cand  = '0;
    inc   = '0;
    grant = '0;
    gnt_v = '0;
    for (int o = 0; o < NPORTS; o++) begin
      elig[o]     = '0;
      gnt_idx[o]  = '0;
      ptr_nxt[o]  = '0;
      win_flit[o] = '0;
    end
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        // While output o is locked, only the lock owner may compete for it.
        elig[o][i] = in_req[i*NPORTS + o] & (~lock_v[o] | (lock_own[o] == PTRW'(i)));
      end
      for (int k = 0; k < NPORTS; k++) begin
        cand = {1'b0, ptr[o]} + (PTRW+1)'(k);
        if (cand >= NPORTS_W) cand = cand - NPORTS_W;
        if (!gnt_v[o] && elig[o][cand[PTRW-1:0]]) begin
          gnt_v[o]   = 1'b1;
          gnt_idx[o] = cand[PTRW-1:0];
        end
      end
      grant[o*NPORTS + int'(gnt_idx[o])] = gnt_v[o];
      win_flit[o] = in_data[int'(gnt_idx[o])*DATASIZE +: DATASIZE];
      inc         = {1'b0, gnt_idx[o]} + (PTRW+1)'(1);
      ptr_nxt[o]  = (inc == NPORTS_W) ? '0 : inc[PTRW-1:0];
    end
  end

  assign xfer = gnt_v & ~out_full;

  // An input asks for at most one output, so it is consumed when that
  // output transfers with this input as the winner.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NPORTS; i++) begin
      in_ready[i] = ~(|in_req[i*NPORTS +: NPORTS]);
      for (int o = 0; o < NPORTS; o++) begin
        if (xfer[o] && (gnt_idx[o] == PTRW'(i))) in_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      lock_v    <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        ptr[o]      <= '0;
        lock_own[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (!out_full[o]) begin
          out_valid[o]                      <= gnt_v[o];
          out_data[o*DATASIZE +: DATASIZE]  <= gnt_v[o] ? win_flit[o] : '0;
          if (gnt_v[o]) begin
            case (win_flit[o][1:0])
              FT_SINGLE: ptr[o] <= ptr_nxt[o];
              FT_HEAD: begin
                lock_v[o]   <= 1'b1;
                lock_own[o] <= gnt_idx[o];
              end
              FT_TAIL: begin
                ptr[o] <= ptr_nxt[o];
                if (lock_v[o] && (lock_own[o] == gnt_idx[o])) lock_v[o] <= 1'b0;
              end
              default: ;  // body: the pointer and the lock are unchanged
            endcase
          end
        end
      end
    end
  end

endmodule
